// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM states, default parameters and line levels for fifo_uart_tx (parity via FIFO_UART_TX_PARITY_EN)
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam int DEF_WIDTH        = 8;
   localparam int DEF_CLKS_PER_BIT = 16;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;
   localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: free-running 0..CLKS_PER_BIT-1 bit timer, held at 0 while clear is high
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   output logic             tick,
   output logic [CNT_W-1:0] count
);

   assign tick = count == CNT_W'(CLKS_PER_BIT - 1);

   // count within a bit, wrapping at the bit boundary so every bit is exactly CLKS_PER_BIT cycles
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear || tick)
         count <= '0;
      else
         count <= count + 1'b1;
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a synchronous FIFO and sends them as UART frames (FIFO_UART_TX_PARITY_EN adds even parity)
module fifo_uart_tx
   import uart_tx_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT),
   parameter int IDX_W        = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tx_en,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_rdata,
   output logic             fifo_rd_en,
   output logic             tx,
   output logic             busy,
   output logic             frame_done
);

   state_t           state;
   logic [WIDTH-1:0] shift_reg;
   logic [IDX_W-1:0] bit_idx;
   logic             tick;
   logic [CNT_W-1:0] count;
   logic             clear;
`ifdef FIFO_UART_TX_PARITY_EN
   logic             parity_bit;
`endif

   // the bit timer only runs while a frame is on the line, so START always begins at count 0
   assign clear = state inside {IDLE, REQ, WAIT};

   baud_tick_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT),
      .CNT_W       (CNT_W)
   ) u_baud (
      .clk  (clk),
      .reset(reset),
      .clear(clear),
      .tick (tick),
      .count(count)
   );

   // frame sequencer; tx/busy/frame_done are loaded with the value of the next cycle so they come straight from flops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         tx         <= LINE_IDLE;
         fifo_rd_en <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         shift_reg  <= '0;
         bit_idx    <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         fifo_rd_en <= 1'b0;
         frame_done <= (state == STOP) && (count == CNT_W'(CLKS_PER_BIT - 2));
         case (state)
            IDLE:
               if (tx_en && !fifo_empty) begin
                  state      <= REQ;
                  fifo_rd_en <= 1'b1;
                  busy       <= 1'b1;
               end
            REQ:
               state <= WAIT;
            WAIT: begin
               state     <= START;
               shift_reg <= fifo_rdata;
               tx        <= LINE_START;
`ifdef FIFO_UART_TX_PARITY_EN
               parity_bit <= ^fifo_rdata;
`endif
            end
            START:
               if (tick) begin
                  state   <= DATA;
                  tx      <= shift_reg[0];
                  bit_idx <= '0;
               end
            DATA:
               if (tick) begin
                  shift_reg <= shift_reg >> 1;
                  bit_idx   <= bit_idx + 1'b1;
                  if (bit_idx == IDX_W'(WIDTH - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                     state <= PARITY;
                     tx    <= parity_bit;
`else
                     state <= STOP;
                     tx    <= LINE_STOP;
`endif
                  end else begin
                     tx <= shift_reg[1];
                  end
               end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:
               if (tick) begin
                  state <= STOP;
                  tx    <= LINE_STOP;
               end
`endif
            STOP:
               if (tick) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            default: begin
               state <= IDLE;
               tx    <= LINE_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of fifo_uart_tx against a small FIFO model (parity frames when FIFO_UART_TX_PARITY_EN is defined)
module tb_fifo_uart_tx;

   localparam int W   = 8;
   localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk        = 1'b0;
   logic       reset      = 1'b0;
   logic       tx_en      = 1'b0;
   logic [7:0] fifo_rdata = 8'h00;
   logic       fifo_empty;
   logic       fifo_rd_en;
   logic       tx;
   logic       busy;
   logic       frame_done;

   logic [7:0] mem [16];
   int wp       = 0;
   int rp       = 0;
   int pops     = 0;
   int rd_total = 0;
   int rd_bad   = 0;
   int checks   = 0;
   int errors   = 0;

   assign fifo_empty = (wp == rp);

   always #5 clk = ~clk;

   fifo_uart_tx #(
      .WIDTH       (W),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .tx_en     (tx_en),
      .fifo_empty(fifo_empty),
      .fifo_rdata(fifo_rdata),
      .fifo_rd_en(fifo_rd_en),
      .tx        (tx),
      .busy      (busy),
      .frame_done(frame_done)
   );

   // FIFO read side: rdata valid the cycle after rd_en is sampled
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         rd_total <= rd_total + 1;
         if (fifo_empty)
            rd_bad <= rd_bad + 1;
         else begin
            fifo_rdata <= mem[rp[3:0]];
            rp         <= rp + 1;
            pops       <= pops + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      mem[wp[3:0]] = d;
      wp++;
   endtask

   task automatic frame(input logic [7:0] w, input int drop_at, input string tag,
                        output int gap, output int idle_lo);
      int t, glitch, fd_cyc, fd_cnt, busy_lo;
      logic [10:0] got, exp;
      t = 0; glitch = 0; fd_cyc = 0; fd_cnt = 0; busy_lo = 0; idle_lo = 0; got = '0;
      while (tx !== 1'b0 && t < 200) begin
         @(negedge clk);
         t++;
         if (busy !== 1'b1) idle_lo++;
      end
      gap = t - 1;
      chk({tag, " start"}, 32'(tx), 32'd0);
      for (int c = 0; c < NB * CPB; c++) begin
         if (c > 0) @(negedge clk);
         if (c == drop_at) tx_en = 1'b0;
         if (c % CPB == 0) got[c / CPB] = tx;
         else if (tx !== got[c / CPB]) glitch++;
         if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_cyc = c + 1;
         end
         if (busy !== 1'b1) busy_lo++;
      end
`ifdef FIFO_UART_TX_PARITY_EN
      exp = {1'b1, ^w, w, 1'b0};
`else
      exp = {2'b01, w, 1'b0};
`endif
      chk({tag, " bits"}, 32'(got), 32'(exp));
      chk({tag, " bit hold"}, glitch, 0);
      chk({tag, " frame_done cycle"}, fd_cyc, NB * CPB);
      chk({tag, " frame_done pulses"}, fd_cnt, 1);
      chk({tag, " busy in frame"}, busy_lo, 0);
   endtask

   initial begin
      int g, il, tx_lo, t;
      // asynchronous reset between edges
      #1 reset = 1'b1;
      #1;
      chk("reset tx", 32'(tx), 32'd1);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset rd_en", 32'(fifo_rd_en), 32'd0);
      chk("reset frame_done", 32'(frame_done), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      tx_en = 1'b1;
      // empty FIFO: nothing popped, line idle
      tx_lo = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1) tx_lo++;
      end
      chk("empty rd_en", rd_total, 0);
      chk("empty tx", tx_lo, 0);
      chk("empty busy", 32'(busy), 32'd0);
      // single word
      push(8'hA5);
      frame(8'hA5, -1, "a5", g, il);
      chk("a5 pops", pops, 1);
      chk("a5 rd_en cycles", rd_total, 1);
      // back-to-back frames
      push(8'h01);
      push(8'hFF);
      frame(8'h01, -1, "b2b 01", g, il);
      frame(8'hFF, -1, "b2b ff", g, il);
      chk("b2b gap", g, 3);
      chk("b2b busy low in gap", il, 1);
      chk("b2b pops", pops, 3);
      // tx_en dropped mid-frame: frame completes, no further pop
      push(8'h5A);
      push(8'h77);
      frame(8'h5A, 15, "drop 5a", g, il);
      repeat (20) @(negedge clk);
      chk("drop pops", pops, 4);
      chk("drop busy", 32'(busy), 32'd0);
      chk("drop tx", 32'(tx), 32'd1);
      tx_en = 1'b1;
      frame(8'h77, -1, "resume 77", g, il);
      chk("resume pops", pops, 5);
      // reset during data bit 3 of 0x3C
      push(8'h3C);
      push(8'h99);
      t = 0;
      while (tx !== 1'b0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("rst start", 32'(tx), 32'd0);
      repeat (17) @(negedge clk);
      chk("rst data bit3", 32'(tx), 32'd1);
      chk("rst pops before", pops, 6);
      #2 reset = 1'b1;
      #1;
      chk("rst mid tx", 32'(tx), 32'd1);
      chk("rst mid busy", 32'(busy), 32'd0);
      chk("rst mid frame_done", 32'(frame_done), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      frame(8'h99, -1, "after rst 99", g, il);
      chk("after rst pops", pops, 7);
      // parity-relevant words (even parity 1 and 0 when enabled)
      push(8'h07);
      push(8'h03);
      frame(8'h07, -1, "w07", g, il);
      frame(8'h03, -1, "w03", g, il);
      chk("final pops", pops, 9);
      chk("rd_en while empty", rd_bad, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
